// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer driving a single-ported
// instruction memory.
//
// Ports:
//   clk             - single clock; all state changes on rising edge
//   reset           - asynchronous, active-low reset
//   stall           - pipeline hold request; fetch paused while high
//   halt            - stop fetching until the next reset
//   redirect_valid  - branch/jump redirect strobe
//   redirect_target - new PC for a redirect
//   imem_ready      - instruction memory completes the current fetch
//   imem_req        - fetch request (high only while fetching)
//   imem_addr       - fetch address, always equal to pc
//   instr_valid     - one-cycle pulse: fetch at instr_pc completed
//   instr_pc        - PC of the most recent completed fetch
//   pc              - current program counter
//   fetch_count     - saturating count of delivered instructions
//   state           - FSM state (BOOT=0, FETCH=1, STALL=2, HALTED=3)
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'd0,
  parameter logic [31:0] PC_LIMIT     = 32'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic [15:0] fetch_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      cur_state;
  logic [31:0] seq_pc;

  // Wrap uses >= so a redirect target beyond PC_LIMIT also wraps on its
  // next sequential step instead of counting upward.
  assign seq_pc    = (pc >= PC_LIMIT) ? RESET_VECTOR : pc + 32'd1;

  assign imem_req  = (cur_state == FETCH);
  assign imem_addr = pc;
  assign state     = cur_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state   <= BOOT;
      pc          <= RESET_VECTOR;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      instr_valid <= 1'b0;
      unique case (cur_state)
        BOOT: cur_state <= FETCH;

        FETCH: begin
          // Priority: halt > redirect > stall > sequential fetch. Any
          // fetch completing alongside a higher-priority event is dropped.
          if (halt) begin
            cur_state <= HALTED;
          end else if (redirect_valid) begin
            pc <= redirect_target;
          end else if (stall) begin
            cur_state <= STALL;
          end else if (imem_ready) begin
            instr_valid <= 1'b1;
            instr_pc    <= pc;
            pc          <= seq_pc;
            if (fetch_count != '1) begin
              fetch_count <= fetch_count + 16'd1;
            end
          end
        end

        STALL: begin
          if (halt) begin
            cur_state <= HALTED;
          end else begin
            if (redirect_valid) begin
              pc <= redirect_target;
            end
            // Leave once stall is seen low; the held pc is refetched.
            if (!stall) begin
              cur_state <= FETCH;
            end
          end
        end

        HALTED: cur_state <= HALTED;

        default: cur_state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'd0;
  localparam logic [31:0] LIM = 32'd31;

  localparam int M_BOOT   = 0;
  localparam int M_FETCH  = 1;
  localparam int M_STALL  = 2;
  localparam int M_HALTED = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic [15:0] fetch_count;
  logic [1:0]  state;

  pc_sequencer #(.RESET_VECTOR(RV), .PC_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .pc(pc),
    .fetch_count(fetch_count), .state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int          m_st;
  logic [31:0] m_pc;
  logic        m_iv;
  logic [31:0] m_ipc;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_BOOT; m_pc = RV; m_iv = 1'b0; m_ipc = '0; m_cnt = 0;
  endtask

  // One clock of behaviour: pick the single winning event for the cycle.
  task automatic model_edge();
    m_iv = 1'b0;
    if (m_st == M_BOOT) m_st = M_FETCH;
    else if (m_st == M_HALTED) m_st = M_HALTED;
    else if (halt) m_st = M_HALTED;
    else begin
      if (redirect_valid) m_pc = redirect_target;
      if (m_st == M_STALL) begin
        if (!stall) m_st = M_FETCH;
      end else if (!redirect_valid) begin
        if (stall) m_st = M_STALL;
        else if (imem_ready) begin
          m_iv  = 1'b1;
          m_ipc = m_pc;
          m_pc  = (m_pc >= LIM) ? RV : m_pc + 32'd1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end
  endtask

  task automatic compare();
    chk("state", {30'd0, state}, m_st);
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", {31'd0, imem_req}, (m_st == M_FETCH) ? 32'd1 : 32'd0);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_iv});
    chk("instr_pc", instr_pc, m_ipc);
    chk("fetch_count", {16'd0, fetch_count}, m_cnt);
  endtask

  task automatic step(input logic st, input logic hl, input logic rv,
                      input logic [31:0] rt, input logic rdy);
    stall = st; halt = hl; redirect_valid = rv; redirect_target = rt; imem_ready = rdy;
    @(posedge clk);
    model_edge();
    #1 compare();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear with no clock edge.
  task automatic do_reset();
    stall = 0; halt = 0; redirect_valid = 0; imem_ready = 0;
    #2 reset = 1'b0;
    #1 model_reset();
    chk("rst_pc", pc, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_count", {16'd0, fetch_count}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_iv", {31'd0, instr_valid}, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_pc(input logic [31:0] target);
    int n = 0;
    while (m_pc != target && n < 100) begin
      step(0, 0, 0, '0, 1);
      n++;
    end
    if (m_pc != target) begin
      fails++; tests++;
      $display("FAIL run_to_pc: timeout, pc %0d target %0d", m_pc, target);
    end
  endtask

  initial begin
    logic [31:0] got[$];
    logic st, hl, rv, rdy;
    logic [31:0] rt;
    int n;
    int halted_for;

    // Power-up reset
    model_reset();
    #3;
    chk("por_pc", pc, 32'd0);
    chk("por_state", {30'd0, state}, 32'd0);
    chk("por_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Continuous fetch: 0..31 then wrap to 0,1
    step(0, 0, 0, '0, 1);
    chk("boot_iv", {31'd0, instr_valid}, 32'd0);
    chk("boot_state", {30'd0, state}, 32'd1);
    n = 0;
    while (got.size() < 34 && n < 60) begin
      step(0, 0, 0, '0, 1);
      if (instr_valid) begin
        got.push_back(instr_pc);
        if (got.size() == 33) chk("count33", {16'd0, fetch_count}, 32'd33);
      end
      n++;
    end
    chk("pulses", got.size(), 32'd34);
    foreach (got[i]) chk("seq_pc", got[i], i % 32);

    // imem_ready low for 3 cycles at pc=5
    do_reset();
    step(0, 0, 0, '0, 1);
    run_to_pc(32'd5);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0, 0);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'd5);
      chk("wait_iv", {31'd0, instr_valid}, 32'd0);
    end
    step(0, 0, 0, '0, 1);
    chk("wait_done_iv", {31'd0, instr_valid}, 32'd1);
    chk("wait_done_pc", instr_pc, 32'd5);

    // Redirect to 20 at pc=7 with ready high
    run_to_pc(32'd7);
    step(0, 0, 1, 32'd20, 1);
    chk("redir_iv", {31'd0, instr_valid}, 32'd0);
    chk("redir_pc", pc, 32'd20);
    step(0, 0, 0, '0, 1);
    chk("redir_ipc0", instr_pc, 32'd20);
    step(0, 0, 0, '0, 1);
    chk("redir_ipc1", instr_pc, 32'd21);

    // Redirect beyond PC_LIMIT wraps on the next sequential step
    step(0, 0, 1, 32'd100, 0);
    step(0, 0, 0, '0, 1);
    chk("far_ipc", instr_pc, 32'd100);
    chk("far_wrap", pc, 32'd0);

    // Stall 2 cycles at pc=10 with a redirect to 3 inside the stall
    run_to_pc(32'd10);
    step(1, 0, 0, '0, 1);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_iv", {31'd0, instr_valid}, 32'd0);
    chk("stall_pc", pc, 32'd10);
    step(1, 0, 1, 32'd3, 1);
    chk("stall_state", {30'd0, state}, 32'd2);
    chk("stall_redir", pc, 32'd3);
    step(0, 0, 0, '0, 1);
    chk("unstall_state", {30'd0, state}, 32'd1);
    step(0, 0, 0, '0, 1);
    chk("unstall_ipc", instr_pc, 32'd3);

    // Halt + redirect at pc=12: halt wins and sticks
    run_to_pc(32'd12);
    step(0, 1, 1, 32'd25, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 32'd4, 1);
      chk("halt_state", {30'd0, state}, 32'd3);
      chk("halt_pc", pc, 32'd12);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
    end

    // Reset in the middle of a fetch at pc=9
    do_reset();
    step(0, 0, 0, '0, 1);
    run_to_pc(32'd9);
    step(0, 0, 0, '0, 0);
    do_reset();
    step(0, 0, 0, '0, 1);
    chk("post_rst_iv", {31'd0, instr_valid}, 32'd0);

    // Randomized traffic
    halted_for = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0 || halted_for > 40) begin
        do_reset();
        halted_for = 0;
      end
      st  = ($urandom_range(0, 4) == 0);
      hl  = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       rt = 32'($urandom_range(0, 31));
        1:       rt = 32'd31;
        2:       rt = 32'hFFFF_FFFF;
        default: rt = 32'($urandom_range(32, 1000));
      endcase
      step(st, hl, rv, rt, rdy);
      if (m_st == M_HALTED) halted_for++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
